// File: rtl/wave_defs.sv
// Shared definitions for the waveform capture path: state encoding and default widths.
package wave_defs;

  localparam int unsigned WC_ADDR_W   = 8;
  localparam int unsigned WC_SAMPLE_W = 16;
  localparam int unsigned WC_OUT_W    = 8;

  typedef enum logic [1:0] {
    WC_ARMED  = 2'd0,
    WC_ACTIVE = 2'd1,
    WC_WAIT   = 2'd2
  } wc_state_e;

endpackage

// File: rtl/wave_capture_if.sv
// Sample-stream input and display-RAM write port of the waveform capture block.
interface wave_capture_if #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned OUT_W    = 8
);
  logic                new_sample_ready;
  logic [SAMPLE_W-1:0] new_sample_in;
  logic                wave_display_idle;
  logic [ADDR_W:0]     write_address;
  logic                write_enable;
  logic [OUT_W-1:0]    write_sample;
  logic                read_index;

  // master: sample source / display side; slave: the capture block
  modport master (
    output new_sample_ready, new_sample_in, wave_display_idle,
    input  write_address, write_enable, write_sample, read_index
  );

  modport slave (
    input  new_sample_ready, new_sample_in, wave_display_idle,
    output write_address, write_enable, write_sample, read_index
  );
endinterface

// File: rtl/dffr.sv
// Flop bank with synchronous active-high reset to zero.
module dffr #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end
endmodule

// File: rtl/dffre.sv
// Flop bank with synchronous active-high reset to zero and load enable.
module dffre #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end
endmodule

// File: rtl/wave_capture_zero_cross_detector.sv
// Positive-going zero-crossing detector on a strobed sample sign bit.
module wave_capture_zero_cross_detector (
  input  logic clk,
  input  logic reset,
  input  logic strobe_i,
  input  logic sign_i,
  output logic cross_c_o
);
  logic prev_neg_q;

  // Sign of the most recent strobed sample; clears on reset so the first sample cannot trigger.
  dffre #(.W(1)) u_prev_neg (
    .clk   (clk),
    .reset (reset),
    .en    (strobe_i),
    .d     (sign_i),
    .q     (prev_neg_q)
  );

  assign cross_c_o = strobe_i & prev_neg_q & ~sign_i;
endmodule

// File: rtl/wave_capture.sv
// Captures one trigger-aligned waveform per display frame into a double-buffered RAM.
module wave_capture
  import wave_defs::*;
#(
  parameter int unsigned ADDR_W   = WC_ADDR_W,
  parameter int unsigned SAMPLE_W = WC_SAMPLE_W,
  parameter int unsigned OUT_W    = WC_OUT_W
) (
  input  logic           clk,
  input  logic           reset,
  wave_capture_if.slave  bus
);
  logic [1:0]          state_raw;
  wc_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   count_q, count_d;
  logic                rd_idx_q, rd_idx_d;
  logic                we_q, we_d;
  logic [ADDR_W:0]     addr_q, addr_d;
  logic [OUT_W-1:0]    data_q, data_d;
  logic [SAMPLE_W-1:0] sample;
  logic [OUT_W-1:0]    disp_sample;
  logic                strobe;
  logic                cross_c;
  logic                unused_low_bits;

  assign sample = bus.new_sample_in;
  assign strobe = bus.new_sample_ready;
  assign state_q = wc_state_e'(state_raw);

  // Top OUT_W bits with the sign flipped: signed -> offset binary.
  assign disp_sample = {~sample[SAMPLE_W-1], sample[SAMPLE_W-2 -: OUT_W-1]};
  assign unused_low_bits = ^sample[SAMPLE_W-OUT_W-1:0];

  wave_capture_zero_cross_detector u_zcd (
    .clk       (clk),
    .reset     (reset),
    .strobe_i  (strobe),
    .sign_i    (sample[SAMPLE_W-1]),
    .cross_c_o (cross_c)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_idx_d = rd_idx_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    unique case (state_q)
      WC_ARMED: begin
        if (cross_c) begin
          we_d    = 1'b1;
          addr_d  = {~rd_idx_q, ADDR_W'(0)};
          data_d  = disp_sample;
          count_d = ADDR_W'(1);
          state_d = WC_ACTIVE;
        end
      end
      WC_ACTIVE: begin
        // The terminal write wraps count to zero on its way to WAIT.
        if (strobe) begin
          we_d    = 1'b1;
          addr_d  = {~rd_idx_q, count_q};
          data_d  = disp_sample;
          count_d = count_q + ADDR_W'(1);
          if (count_q == {ADDR_W{1'b1}}) state_d = WC_WAIT;
        end
      end
      WC_WAIT: begin
        if (bus.wave_display_idle) begin
          rd_idx_d = ~rd_idx_q;
          state_d  = WC_ARMED;
        end
      end
      default: state_d = WC_ARMED;
    endcase
  end

  dffr #(.W(2))        u_state (.clk(clk), .reset(reset), .d(state_d),  .q(state_raw));
  dffr #(.W(ADDR_W))   u_count (.clk(clk), .reset(reset), .d(count_d),  .q(count_q));
  dffr #(.W(1))        u_rdidx (.clk(clk), .reset(reset), .d(rd_idx_d), .q(rd_idx_q));
  dffr #(.W(1))        u_we    (.clk(clk), .reset(reset), .d(we_d),     .q(we_q));
  dffr #(.W(ADDR_W+1)) u_addr  (.clk(clk), .reset(reset), .d(addr_d),   .q(addr_q));
  dffr #(.W(OUT_W))    u_data  (.clk(clk), .reset(reset), .d(data_d),   .q(data_q));

  assign bus.write_enable  = we_q;
  assign bus.write_address = addr_q;
  assign bus.write_sample  = data_q;
  assign bus.read_index    = rd_idx_q;
endmodule

// File: tb/tb_wave_capture.sv
// Directed bench for wave_capture: trigger, fill, buffer flip, reset abort, back-to-back.
module tb_wave_capture;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  wave_capture_if #(.ADDR_W(8), .SAMPLE_W(16), .OUT_W(8)) bus ();

  wave_capture #(.ADDR_W(8), .SAMPLE_W(16), .OUT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one sample for exactly one cycle; returns 1 time unit after the edge.
  task automatic strobe(input logic [15:0] v);
    bus.new_sample_ready = 1'b1;
    bus.new_sample_in    = v;
    @(posedge clk); #1;
    bus.new_sample_ready = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.new_sample_ready  = 1'b0;
    bus.new_sample_in     = 16'h0000;
    bus.wave_display_idle = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (bus.write_enable !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", bus.write_enable); end
    checks++; if (bus.write_address !== 9'h000) begin failures++; $display("FAIL reset_addr got=%h exp=000", bus.write_address); end
    checks++; if (bus.write_sample !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.write_sample); end
    checks++; if (bus.read_index !== 1'b0) begin failures++; $display("FAIL reset_ridx got=%b exp=0", bus.read_index); end
  endtask

  task automatic test_no_trigger();
    strobe(16'h1000);
    checks++; if (bus.write_enable !== 1'b0) begin failures++; $display("FAIL notrig_we0 got=%b exp=0", bus.write_enable); end
    strobe(16'h2000);
    checks++; if (bus.write_enable !== 1'b0) begin failures++; $display("FAIL notrig_we1 got=%b exp=0", bus.write_enable); end
    checks++; if (bus.read_index !== 1'b0) begin failures++; $display("FAIL notrig_ridx got=%b exp=0", bus.read_index); end
  endtask

  task automatic test_first_crossing();
    strobe(16'hF000);
    checks++; if (bus.write_enable !== 1'b0) begin failures++; $display("FAIL neg_we got=%b exp=0", bus.write_enable); end
    strobe(16'h0100);
    checks++; if (bus.write_enable !== 1'b1) begin failures++; $display("FAIL cross_we got=%b exp=1", bus.write_enable); end
    checks++; if (bus.write_address !== 9'h100) begin failures++; $display("FAIL cross_addr got=%h exp=100", bus.write_address); end
    checks++; if (bus.write_sample !== 8'h81) begin failures++; $display("FAIL cross_data got=%h exp=81", bus.write_sample); end
    idle_cycle();
    checks++; if (bus.write_enable !== 1'b0) begin failures++; $display("FAIL gap_we got=%b exp=0", bus.write_enable); end
    checks++; if (bus.write_address !== 9'h100) begin failures++; $display("FAIL gap_addr_hold got=%h exp=100", bus.write_address); end
  endtask

  task automatic test_fill();
    logic [8:0] exp_addr;
    for (int i = 1; i < 256; i++) begin
      strobe(16'h7FFF);
      exp_addr = 9'h100 + 9'(i);
      checks++; if (bus.write_enable !== 1'b1 || bus.write_address !== exp_addr || bus.write_sample !== 8'hFF) begin
        failures++;
        $display("FAIL fill_%0d got we=%b addr=%h data=%h exp we=1 addr=%h data=ff", i, bus.write_enable, bus.write_address, bus.write_sample, exp_addr);
      end
    end
    strobe(16'h7FFF);
    checks++; if (bus.write_enable !== 1'b0) begin failures++; $display("FAIL wait_we got=%b exp=0", bus.write_enable); end
    checks++; if (bus.write_address !== 9'h1FF) begin failures++; $display("FAIL wait_addr_hold got=%h exp=1ff", bus.write_address); end
    strobe(16'h8000);
    strobe(16'h0000);
    checks++; if (bus.write_enable !== 1'b0) begin failures++; $display("FAIL wait_cross_ignored got=%b exp=0", bus.write_enable); end
    checks++; if (bus.read_index !== 1'b0) begin failures++; $display("FAIL wait_ridx got=%b exp=0", bus.read_index); end
  endtask

  task automatic test_flip();
    bus.wave_display_idle = 1'b1;
    @(posedge clk); #1;
    bus.wave_display_idle = 1'b0;
    checks++; if (bus.read_index !== 1'b1) begin failures++; $display("FAIL flip_ridx got=%b exp=1", bus.read_index); end
    strobe(16'h8000);
    checks++; if (bus.write_enable !== 1'b0) begin failures++; $display("FAIL flip_neg_we got=%b exp=0", bus.write_enable); end
    strobe(16'h0000);
    checks++; if (bus.write_enable !== 1'b1) begin failures++; $display("FAIL flip_cross_we got=%b exp=1", bus.write_enable); end
    checks++; if (bus.write_address !== 9'h000) begin failures++; $display("FAIL flip_cross_addr got=%h exp=000", bus.write_address); end
    checks++; if (bus.write_sample !== 8'h80) begin failures++; $display("FAIL flip_cross_data got=%h exp=80", bus.write_sample); end
  endtask

  task automatic test_reset_mid();
    for (int i = 1; i < 10; i++) begin
      strobe(16'h0100);
      checks++; if (bus.write_enable !== 1'b1 || bus.write_address !== 9'(i)) begin
        failures++;
        $display("FAIL mid_%0d got we=%b addr=%h exp we=1 addr=%h", i, bus.write_enable, bus.write_address, 9'(i));
      end
    end
    reset = 1'b1;
    bus.new_sample_ready = 1'b1;
    bus.new_sample_in    = 16'h0100;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.new_sample_ready = 1'b0;
    checks++; if (bus.write_enable !== 1'b0) begin failures++; $display("FAIL mid_rst_we got=%b exp=0", bus.write_enable); end
    checks++; if (bus.read_index !== 1'b0) begin failures++; $display("FAIL mid_rst_ridx got=%b exp=0", bus.read_index); end
    checks++; if (bus.write_address !== 9'h000) begin failures++; $display("FAIL mid_rst_addr got=%h exp=000", bus.write_address); end
    strobe(16'h0000);
    checks++; if (bus.write_enable !== 1'b0) begin failures++; $display("FAIL post_rst_first got=%b exp=0", bus.write_enable); end
    strobe(16'hF000);
    strobe(16'h0100);
    checks++; if (bus.write_enable !== 1'b1 || bus.write_address !== 9'h100 || bus.write_sample !== 8'h81) begin
      failures++;
      $display("FAIL post_rst_cross got we=%b addr=%h data=%h exp we=1 addr=100 data=81", bus.write_enable, bus.write_address, bus.write_sample);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] idx;
    logic [8:0] exp_addr;
    logic [7:0] exp_data;
    for (int i = 1; i < 256; i++) begin
      idx = 8'(i);
      strobe({idx, 8'h00});
      exp_addr = {1'b1, idx};
      exp_data = idx ^ 8'h80;
      checks++; if (bus.write_enable !== 1'b1 || bus.write_address !== exp_addr || bus.write_sample !== exp_data) begin
        failures++;
        $display("FAIL b2b_%0d got we=%b addr=%h data=%h exp we=1 addr=%h data=%h", i, bus.write_enable, bus.write_address, bus.write_sample, exp_addr, exp_data);
      end
    end
    bus.new_sample_ready  = 1'b1;
    bus.new_sample_in     = 16'h8000;
    bus.wave_display_idle = 1'b1;
    @(posedge clk); #1;
    bus.new_sample_ready  = 1'b0;
    bus.wave_display_idle = 1'b0;
    checks++; if (bus.write_enable !== 1'b0) begin failures++; $display("FAIL coincide_we got=%b exp=0", bus.write_enable); end
    checks++; if (bus.read_index !== 1'b1) begin failures++; $display("FAIL coincide_ridx got=%b exp=1", bus.read_index); end
    strobe(16'h0000);
    checks++; if (bus.write_enable !== 1'b1 || bus.write_address !== 9'h000 || bus.write_sample !== 8'h80) begin
      failures++;
      $display("FAIL coincide_prevneg got we=%b addr=%h data=%h exp we=1 addr=000 data=80", bus.write_enable, bus.write_address, bus.write_sample);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_no_trigger();
    test_first_crossing();
    test_fill();
    test_flip();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
